// File: rtl/alu_pkg.sv
// Shared opcode values, FSM state encoding and a dispatch helper for the multicycle ALU.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_NOR   = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_LUI   = 4'b0101;
    localparam logic [3:0] OP_SLT   = 4'b0110;
    localparam logic [3:0] OP_SLL   = 4'b0111;
    localparam logic [3:0] OP_SRL   = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIVU  = 4'b1010;
    localparam logic [3:0] OP_MFHI  = 4'b1011;
    localparam logic [3:0] OP_MFLO  = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ops that need the bit-serial datapath; divide by zero is resolved in one cycle.
    function automatic logic is_iterative(input logic [3:0] op, input logic divisor_zero);
        return (op == OP_MULTU) || ((op == OP_DIVU) && !divisor_zero);
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Bit-serial unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// acc holds the high half / partial remainder, qp the low half / quotient.
// finish is asserted during the last iteration cycle; hi_next/lo_next then carry the final result.
module mult_div_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             div_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             finish,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] qp;
    logic [WIDTH-1:0] opnd;
    logic [CNT_W-1:0] cnt;
    logic             run;
    logic             mode;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic             fits;

    // One iteration of either algorithm, computed from the current registers.
    always_comb begin
        add_sum = {1'b0, acc} + {1'b0, opnd};
        shifted = {acc, qp[WIDTH-1]};
        fits    = (shifted >= {1'b0, opnd});
        hi_next = acc;
        lo_next = qp;
        if (mode) begin
            // Trial subtract fits in WIDTH bits whenever it is taken (remainder < divisor).
            if (fits) begin
                hi_next = shifted[WIDTH-1:0] - opnd;
                lo_next = {qp[WIDTH-2:0], 1'b1};
            end else begin
                hi_next = shifted[WIDTH-1:0];
                lo_next = {qp[WIDTH-2:0], 1'b0};
            end
        end else if (qp[0]) begin
            {hi_next, lo_next} = {add_sum, qp[WIDTH-1:1]};
        end else begin
            {hi_next, lo_next} = {1'b0, acc, qp[WIDTH-1:1]};
        end
    end

    assign finish = run && (cnt == CNT_W'(WIDTH - 1));

    // Load operands on go, then iterate exactly WIDTH times.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc  <= '0;
            qp   <= '0;
            opnd <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            mode <= 1'b0;
        end else if (go) begin
            acc  <= '0;
            qp   <= div_mode ? a : b;
            opnd <= div_mode ? b : a;
            mode <= div_mode;
            cnt  <= '0;
            run  <= 1'b1;
        end else if (run) begin
            acc <= hi_next;
            qp  <= lo_next;
            cnt <= cnt + CNT_W'(1);
            if (finish) run <= 1'b0;
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith ops plus bit-serial MULTU/DIVU into HI/LO.
// All results and flags are registered on the edge that enters DONE.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUOperation,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Overflow,
    output logic             DivByZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int SH_W = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SH_W-1:0]  shamt;
    logic [WIDTH-1:0] sc_result;
    logic [WIDTH-1:0] sc_hi;
    logic [WIDTH-1:0] sc_lo;
    logic             sc_ovf;
    logic             sc_dbz;
    logic             sc_hilo_wr;
    logic             iterative;
    logic             md_go;
    logic             md_finish;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;

    assign sum       = A + B;
    assign diff      = A - B;
    assign shamt     = A[SH_W-1:0];
    assign iterative = is_iterative(ALUOperation, (B == '0));
    assign md_go     = (state == ST_IDLE) && start && iterative;

    // Result of every op that completes in one cycle, taken straight from the inputs.
    always_comb begin
        sc_result  = '0;
        sc_hi      = HI;
        sc_lo      = LO;
        sc_ovf     = 1'b0;
        sc_dbz     = 1'b0;
        sc_hilo_wr = 1'b0;
        case (ALUOperation)
            OP_AND: sc_result = A & B;
            OP_OR:  sc_result = A | B;
            OP_NOR: sc_result = ~(A | B);
            OP_ADD: begin
                sc_result = sum;
                sc_ovf    = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                sc_result = diff;
                sc_ovf    = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_LUI: sc_result = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_SLT: sc_result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLL: sc_result = B << shamt;
            OP_SRL: sc_result = B >> shamt;
            // Only the divide-by-zero case of DIVU reaches the single-cycle path.
            OP_DIVU: begin
                sc_result  = '1;
                sc_hi      = A;
                sc_lo      = '1;
                sc_dbz     = 1'b1;
                sc_hilo_wr = 1'b1;
            end
            OP_MFHI: sc_result = HI;
            OP_MFLO: sc_result = LO;
            default: sc_result = '0;
        endcase
    end

    mult_div_unit #(.WIDTH(WIDTH)) u_md (
        .clk      (clk),
        .reset    (reset),
        .go       (md_go),
        .div_mode (ALUOperation == OP_DIVU),
        .a        (A),
        .b        (B),
        .finish   (md_finish),
        .hi_next  (md_hi),
        .lo_next  (md_lo)
    );

    // Control FSM with registered busy/done and result/flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            ALUResult <= '0;
            Zero      <= 1'b0;
            Overflow  <= 1'b0;
            DivByZero <= 1'b0;
            HI        <= '0;
            LO        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (iterative) begin
                            state <= ST_CALC;
                        end else begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            ALUResult <= sc_result;
                            Zero      <= (sc_result == '0);
                            Overflow  <= sc_ovf;
                            DivByZero <= sc_dbz;
                            if (sc_hilo_wr) begin
                                HI <= sc_hi;
                                LO <= sc_lo;
                            end
                        end
                    end
                end
                ST_CALC: begin
                    if (md_finish) begin
                        state     <= ST_DONE;
                        done      <= 1'b1;
                        HI        <= md_hi;
                        LO        <= md_lo;
                        ALUResult <= md_lo;
                        Zero      <= (md_lo == '0);
                        Overflow  <= 1'b0;
                        DivByZero <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu (WIDTH=32) against a plain-arithmetic reference model.
module tb_multicycle_alu;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, zero, ovf, dbz;
    logic [31:0] result, hi, lo;

    int checks = 0;
    int failures = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    multicycle_alu #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset_n),
        .start        (start),
        .ALUOperation (op),
        .A            (a),
        .B            (b),
        .busy         (busy),
        .done         (done),
        .ALUResult    (result),
        .Zero         (zero),
        .Overflow     (ovf),
        .DivByZero    (dbz),
        .HI           (hi),
        .LO           (lo)
    );

    always #5 clk = ~clk;

    // Reference model: architectural meaning of each opcode, updates model HI/LO.
    task automatic model_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                            output logic [31:0] res, output logic ez, output logic eov,
                            output logic edbz, output int elat);
        longint s;
        logic [63:0] p;
        res = '0; eov = 1'b0; edbz = 1'b0;
        case (o)
            4'd0: res = x & y;
            4'd1: res = x | y;
            4'd2: res = ~(x | y);
            4'd3: begin
                res = x + y;
                s = longint'($signed(x)) + longint'($signed(y));
                eov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd4: begin
                res = x - y;
                s = longint'($signed(x)) - longint'($signed(y));
                eov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd5: res = y * 32'd65536;
            4'd6: res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd7: res = y << (x % 32);
            4'd8: res = y >> (x % 32);
            4'd9: begin
                p = {32'd0, x} * {32'd0, y};
                m_hi = p[63:32];
                m_lo = p[31:0];
                res = m_lo;
            end
            4'd10: begin
                if (y == 0) begin
                    m_hi = x;
                    m_lo = 32'hFFFF_FFFF;
                    edbz = 1'b1;
                end else begin
                    m_hi = x % y;
                    m_lo = x / y;
                end
                res = m_lo;
            end
            4'd11: res = m_hi;
            4'd12: res = m_lo;
            default: res = '0;
        endcase
        ez = (res == 0);
        elat = (o == 4'd9 || (o == 4'd10 && y != 0)) ? 33 : 1;
    endtask

    // Issue one operation from a negedge, wait for done, compare everything. Returns at a negedge in IDLE.
    task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
        logic [31:0] eres;
        logic ez, eov, edbz;
        int elat, n;
        model_op(o, x, y, eres, ez, eov, edbz, elat);
        start = 1'b1; op = o; a = x; b = y;
        n = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            n++;
            if (n == 1) begin
                checks++;
                if (busy !== 1'b1) begin failures++; $display("FAIL %s busy: got %b want 1", tag, busy); end
            end
        end while (done !== 1'b1 && n < 100);
        checks++; if (n !== elat) begin failures++; $display("FAIL %s latency: got %0d want %0d", tag, n, elat); end
        checks++; if (result !== eres) begin failures++; $display("FAIL %s result: got %h want %h (op %0d a %h b %h)", tag, result, eres, o, x, y); end
        checks++; if (zero !== ez) begin failures++; $display("FAIL %s zero: got %b want %b", tag, zero, ez); end
        checks++; if (ovf !== eov) begin failures++; $display("FAIL %s overflow: got %b want %b", tag, ovf, eov); end
        checks++; if (dbz !== edbz) begin failures++; $display("FAIL %s divbyzero: got %b want %b", tag, dbz, edbz); end
        checks++; if (hi !== m_hi || lo !== m_lo) begin failures++; $display("FAIL %s hilo: got %h/%h want %h/%h", tag, hi, lo, m_hi, m_lo); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL %s done_pulse: got done %b busy %b want 0 0", tag, done, busy); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, zero, ovf, dbz} !== 5'b0 || result !== 0 || hi !== 0 || lo !== 0) begin
            failures++;
            $display("FAIL reset_state: got busy %b done %b z %b ov %b dz %b res %h hi %h lo %h want all 0",
                     busy, done, zero, ovf, dbz, result, hi, lo);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        do_op(4'd3, 32'd5, 32'd3, "add_5_3");
        do_op(4'd3, 32'h7FFF_FFFF, 32'd1, "add_ovf");
        do_op(4'd4, 32'd7, 32'd7, "sub_zero");
        do_op(4'd9, 32'hFFFF_FFFF, 32'd2, "multu_max");
        checks++; if (hi !== 32'd1 || lo !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_literal: got %h/%h want 00000001/fffffffe", hi, lo); end
        do_op(4'd11, 32'd0, 32'd0, "mfhi");
        do_op(4'd10, 32'd100, 32'd7, "divu_100_7");
        checks++; if (hi !== 32'd2 || lo !== 32'd14) begin failures++; $display("FAIL divu_literal: got %h/%h want 2/14", hi, lo); end
        do_op(4'd10, 32'd9, 32'd0, "divu_by_zero");
        do_op(4'd12, 32'd0, 32'd0, "mflo");
        do_op(4'd5, 32'd0, 32'hABCD_1234, "lui");
        do_op(4'd6, 32'hFFFF_FFFF, 32'd1, "slt_neg");
        do_op(4'd7, 32'd31, 32'd1, "sll_31");
        do_op(4'd8, 32'd35, 32'h8000_0000, "srl_mod");
        do_op(4'd13, 32'd1, 32'd2, "illegal_op");
    endtask

    task automatic test_random();
        logic [31:0] x, y;
        for (int i = 0; i < 60; i++) begin
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 3) == 0) y = $urandom_range(0, 15);
            if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
            do_op(4'($urandom_range(0, 15)), x, y, "random");
        end
    endtask

    // A start pulse during CALC must be ignored and produce no second done.
    task automatic test_ignore_start();
        int dones, first, n;
        logic [31:0] eres;
        logic ez, eov, edbz;
        int elat;
        model_op(4'd9, 32'h1234_5678, 32'h9ABC_DEF0, eres, ez, eov, edbz, elat);
        start = 1'b1; op = 4'd9; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
        dones = 0; first = 0;
        for (n = 1; n <= 45; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 5) begin start = 1'b1; op = 4'd3; a = 32'd1; b = 32'd1; end
            if (done === 1'b1) begin
                dones++;
                if (first == 0) first = n;
                checks++; if (result !== eres) begin failures++; $display("FAIL ignore_result: got %h want %h", result, eres); end
            end
        end
        checks++; if (dones !== 1) begin failures++; $display("FAIL ignore_done_count: got %0d want 1", dones); end
        checks++; if (first !== 33) begin failures++; $display("FAIL ignore_latency: got %0d want 33", first); end
        checks++; if (hi !== m_hi || lo !== m_lo) begin failures++; $display("FAIL ignore_hilo: got %h/%h want %h/%h", hi, lo, m_hi, m_lo); end
    endtask

    // Reset in the middle of MULTU clears everything at once and suppresses done.
    task automatic test_reset_mid();
        int dones;
        start = 1'b1; op = 4'd9; a = 32'hDEAD_BEEF; b = 32'h0000_0123;
        repeat (10) begin @(negedge clk); start = 1'b0; end
        reset_n = 1'b0;
        #1;
        m_hi = '0; m_lo = '0;
        checks++;
        if ({busy, done, zero, ovf, dbz} !== 5'b0 || result !== 0 || hi !== 0 || lo !== 0) begin
            failures++;
            $display("FAIL reset_mid_clear: got busy %b done %b z %b ov %b dz %b res %h hi %h lo %h want all 0",
                     busy, done, zero, ovf, dbz, result, hi, lo);
        end
        dones = 0;
        repeat (3) begin @(negedge clk); if (done === 1'b1) dones++; end
        reset_n = 1'b1;
        repeat (30) begin @(negedge clk); if (done === 1'b1 || busy === 1'b1) dones++; end
        checks++; if (dones !== 0) begin failures++; $display("FAIL reset_mid_no_done: got %0d done/busy cycles want 0", dones); end
        do_op(4'd3, 32'd1, 32'd1, "add_after_reset");
        checks++; if (result !== 32'd2) begin failures++; $display("FAIL add_after_reset_literal: got %h want 2", result); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        @(negedge clk);
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; legal values are even numbers of 8 or more.
REQ-002 SHALL have port clk, input, 1 bit, single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1 bit, request to begin an operation.
REQ-005 SHALL have port ALUOperation, input, 4 bits, operation select.
REQ-006 SHALL have ports A and B, input, WIDTH bits each, operands.
REQ-007 SHALL have port busy, output, 1 bit, operation in progress.
REQ-008 SHALL have port done, output, 1 bit, one-cycle result-valid pulse.
REQ-009 SHALL have port ALUResult, output, WIDTH bits, registered result.
REQ-010 SHALL have ports Zero, Overflow and DivByZero, output, 1 bit each, registered flags.
REQ-011 SHALL have ports HI and LO, output, WIDTH bits each, product/division registers.

Function
REQ-012 SHALL use these opcodes: AND 0000, OR 0001, NOR 0010, ADD 0011, SUB 0100, LUI 0101, SLT 0110, SLL 0111, SRL 1000, MULTU 1001, DIVU 1010, MFHI 1011, MFLO 1100; all other codes give ALUResult 0.
REQ-013 SHALL define LUI as ALUResult = {B[WIDTH/2-1:0], WIDTH/2 zeros}.
REQ-014 SHALL define SLT as signed A<B giving 1, else 0.
REQ-015 SHALL define SLL and SRL (logical) as shifting B by A[clog2(WIDTH)-1:0].
REQ-016 SHALL latch ALUOperation, A and B only when start=1 in state IDLE; start in any other state is ignored.
REQ-017 SHALL implement states IDLE, CALC and DONE; busy = (state != IDLE).
REQ-018 SHALL, for single-cycle ops, move IDLE->DONE on start, giving done=1 in the next cycle (latency 1).
REQ-019 SHALL, for MULTU and DIVU, move IDLE->CALC, stay in CALC for exactly WIDTH cycles, then go to DONE (latency WIDTH+1).
REQ-020 SHALL hold DONE for one cycle with done=1, then return to IDLE; a new start is accepted in the following IDLE cycle.
REQ-021 SHALL implement MULTU as unsigned iterative shift-add, one bit per cycle, with {HI,LO} = A*B.
REQ-022 SHALL implement DIVU as unsigned restoring division, one bit per cycle, with LO = quotient and HI = remainder.
REQ-023 SHALL, for DIVU with B=0, skip CALC (IDLE->DONE), set LO to all ones, HI = A and DivByZero=1.
REQ-024 SHALL set ALUResult = LO for MULTU and DIVU, HI for MFHI and LO for MFLO; HI and LO change only on MULTU or DIVU completion.
REQ-025 SHALL update ALUResult, Zero (ALUResult==0), Overflow (signed overflow, ADD/SUB only, else 0) and DivByZero at the DONE entry edge, and hold them until the next DONE.
REQ-026 SHALL compute ADD and SUB modulo 2^WIDTH.

Reset
REQ-027 SHALL, on reset low, immediately force state IDLE, busy=0, done=0, ALUResult=0, HI=0, LO=0 and all flags 0.
REQ-028 SHALL abandon any in-flight operation on reset with no done pulse; the first start after reset release is accepted normally.

Structure
REQ-029 SHALL place opcode localparams and state encoding in shared package alu_pkg.
REQ-030 SHALL place the iterative multiply/divide datapath (shared accumulator, counter, quotient/product register) in sub-module mult_div_unit, with start/finish handshake to the FSM.

Verification (WIDTH=32)
REQ-031 SHALL cover: ADD A=5, B=3, start -> done next cycle, ALUResult=8, Zero=0, Overflow=0.
REQ-032 SHALL cover: ADD A=0x7FFFFFFF, B=1 -> Overflow=1; SUB A=7, B=7 -> ALUResult=0, Zero=1.
REQ-033 SHALL cover: MULTU A=0xFFFFFFFF, B=2 -> done exactly 33 cycles after start, HI=1, LO=0xFFFFFFFE; then MFHI -> ALUResult=1.
REQ-034 SHALL cover: DIVU A=100, B=7 -> LO=14, HI=2; DIVU A=9, B=0 -> done next cycle, DivByZero=1, LO=0xFFFFFFFF, HI=9.
REQ-035 SHALL cover: start with ADD pulsed during MULTU CALC -> ignored; MULTU result unchanged; exactly one done.
REQ-036 SHALL cover: reset asserted at cycle 10 of MULTU -> all outputs 0 at once, no done; then ADD 1+1 -> ALUResult=2.
